// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the single-bus datapath: IR/CON/stop in,
// every datapath strobe plus ALU opcode and status out.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;

    logic PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, Zin, Zhighout, Zlowout;
    logic HIin, HIout, LOin, LOout, Read, Write, Cout, Gra, Grb, Grc, Rin, Rout;
    logic BAout, CONin, OutportIn, InPortOut;
    logic [4:0] OpCode;
    logic       run;
    logic       illegal;

    modport master (
        input  ir, con_ff, stop,
        output PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, Zin, Zhighout, Zlowout,
        output HIin, HIout, LOin, LOout, Read, Write, Cout, Gra, Grb, Grc, Rin, Rout,
        output BAout, CONin, OutportIn, InPortOut, OpCode, run, illegal
    );

    modport slave (
        output ir, con_ff, stop,
        input  PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, Zin, Zhighout, Zlowout,
        input  HIin, HIout, LOin, LOout, Read, Write, Cout, Gra, Grb, Grc, Rin, Rout,
        input  BAout, CONin, OutportIn, InPortOut, OpCode, run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus RISC datapath: steps through
// fetch (F0-F2) and per-opcode execute steps (T3-T7), one control step per clock.
module control_sequencer #(
    parameter int unsigned MEM_CYCLES = 1,
    parameter logic [4:0]  INC_OP     = 5'b11011,
    parameter logic [4:0]  ADD_OP     = 5'b00011
) (
    input logic                clk,
    input logic                clr,
    control_sequencer_if.master cs_io
);

    localparam logic [3:0] MemWait = 4'(MEM_CYCLES - 1);

    localparam logic [4:0] OpLd   = 5'd0,  OpLdi  = 5'd1,  OpSt   = 5'd2,  OpAdd  = 5'd3;
    localparam logic [4:0] OpSub  = 5'd4,  OpAnd  = 5'd5,  OpOr   = 5'd6,  OpAddi = 5'd12;
    localparam logic [4:0] OpAndi = 5'd13, OpOri  = 5'd14, OpMul  = 5'd15, OpDiv  = 5'd16;
    localparam logic [4:0] OpBr   = 5'd18, OpJr   = 5'd19, OpIn   = 5'd21, OpOut  = 5'd22;
    localparam logic [4:0] OpMfhi = 5'd23, OpMflo = 5'd24, OpNop  = 5'd25, OpHalt = 5'd26;

    typedef enum logic [3:0] {
        StReset, StF0, StF1, StF2, StT3, StT4, StT5, StT6, StT7, StHalted
    } state_e;

    typedef enum logic [3:0] {
        ClsAlu, ClsImm, ClsMul, ClsLd, ClsLdi, ClsSt, ClsBr, ClsJr, ClsIn, ClsOut,
        ClsMfhi, ClsMflo, ClsNop, ClsHalt, ClsIllegal
    } cls_e;

    state_e     state_q;
    logic [3:0] wait_q;
    logic       con_q;
    logic       illegal_q;

    logic [4:0] op;
    logic [4:0] imm_op;
    cls_e       cls;
    logic [2:0] n_steps;
    state_e     boundary;
    logic       ir_unused;

    assign op        = cs_io.ir[31:27];
    assign ir_unused = ^cs_io.ir[26:0];
    assign boundary  = cs_io.stop ? StHalted : StF0;

    // Instruction class and number of execute steps (T3 onward).
    always_comb begin
        cls     = ClsIllegal;
        n_steps = 3'd0;
        imm_op  = OpAdd;
        case (op)
            OpAdd, OpSub, OpAnd, OpOr: begin cls = ClsAlu; n_steps = 3'd3; end
            OpAddi:                    begin cls = ClsImm; n_steps = 3'd3; imm_op = OpAdd; end
            OpAndi:                    begin cls = ClsImm; n_steps = 3'd3; imm_op = OpAnd; end
            OpOri:                     begin cls = ClsImm; n_steps = 3'd3; imm_op = OpOr;  end
            OpMul, OpDiv:              begin cls = ClsMul; n_steps = 3'd4; end
            OpLd:                      begin cls = ClsLd;  n_steps = 3'd5; end
            OpLdi:                     begin cls = ClsLdi; n_steps = 3'd3; end
            OpSt:                      begin cls = ClsSt;  n_steps = 3'd5; end
            OpBr:                      begin cls = ClsBr;  n_steps = 3'd4; end
            OpJr:                      begin cls = ClsJr;  n_steps = 3'd1; end
            OpIn:                      begin cls = ClsIn;  n_steps = 3'd1; end
            OpOut:                     begin cls = ClsOut; n_steps = 3'd1; end
            OpMfhi:                    begin cls = ClsMfhi; n_steps = 3'd1; end
            OpMflo:                    begin cls = ClsMflo; n_steps = 3'd1; end
            OpNop:                     cls = ClsNop;
            OpHalt:                    cls = ClsHalt;
            default:                   cls = ClsIllegal;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StReset;
            wait_q    <= '0;
            con_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // CON is captured so the branch step has no combinational path from con_ff.
            con_q <= cs_io.con_ff;
            case (state_q)
                StReset: state_q <= StF0;
                StF0: begin
                    state_q <= StF1;
                    wait_q  <= MemWait;
                end
                StF1: begin
                    if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
                    else state_q <= StF2;
                end
                StF2: begin
                    if (cls == ClsIllegal) illegal_q <= 1'b1;
                    if (cls == ClsHalt) state_q <= StHalted;
                    else if (n_steps == 3'd0) state_q <= boundary;
                    else state_q <= StT3;
                end
                StT3: state_q <= (n_steps == 3'd1) ? boundary : StT4;
                StT4: state_q <= (n_steps == 3'd2) ? boundary : StT5;
                StT5: begin
                    state_q <= (n_steps == 3'd3) ? boundary : StT6;
                    wait_q  <= MemWait;
                end
                StT6: begin
                    if (cls == ClsLd && wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end else begin
                        state_q <= (n_steps == 3'd4) ? boundary : StT7;
                        wait_q  <= MemWait;
                    end
                end
                StT7: begin
                    if (cls == ClsSt && wait_q != 4'd0) wait_q <= wait_q - 4'd1;
                    else state_q <= boundary;
                end
                StHalted: state_q <= StHalted;
                default:  state_q <= StReset;
            endcase
        end
    end

    assign cs_io.run     = !(state_q inside {StReset, StHalted});
    assign cs_io.illegal = illegal_q;

    always_comb begin
        cs_io.PCin = 1'b0;  cs_io.PCout = 1'b0;    cs_io.IRin = 1'b0;     cs_io.MARin = 1'b0;
        cs_io.MDRin = 1'b0; cs_io.MDRout = 1'b0;   cs_io.Yin = 1'b0;      cs_io.Zin = 1'b0;
        cs_io.Zhighout = 1'b0; cs_io.Zlowout = 1'b0; cs_io.HIin = 1'b0;   cs_io.HIout = 1'b0;
        cs_io.LOin = 1'b0;  cs_io.LOout = 1'b0;    cs_io.Read = 1'b0;     cs_io.Write = 1'b0;
        cs_io.Cout = 1'b0;  cs_io.Gra = 1'b0;      cs_io.Grb = 1'b0;      cs_io.Grc = 1'b0;
        cs_io.Rin = 1'b0;   cs_io.Rout = 1'b0;     cs_io.BAout = 1'b0;    cs_io.CONin = 1'b0;
        cs_io.OutportIn = 1'b0; cs_io.InPortOut = 1'b0;
        cs_io.OpCode = 5'd0;
        case (state_q)
            StF0: begin
                cs_io.PCout = 1'b1; cs_io.MARin = 1'b1; cs_io.Yin = 1'b1; cs_io.Zin = 1'b1;
                cs_io.OpCode = INC_OP;
            end
            StF1: begin
                cs_io.Zlowout = 1'b1; cs_io.PCin = 1'b1; cs_io.Read = 1'b1; cs_io.MDRin = 1'b1;
            end
            StF2: begin
                cs_io.MDRout = 1'b1; cs_io.IRin = 1'b1;
            end
            StT3: begin
                case (cls)
                    ClsAlu, ClsImm: begin cs_io.Grb = 1'b1; cs_io.Rout = 1'b1; cs_io.Yin = 1'b1; end
                    ClsMul: begin cs_io.Gra = 1'b1; cs_io.Rout = 1'b1; cs_io.Yin = 1'b1; end
                    ClsLd, ClsLdi, ClsSt: begin
                        cs_io.Grb = 1'b1; cs_io.BAout = 1'b1; cs_io.Yin = 1'b1;
                    end
                    ClsBr:   begin cs_io.Gra = 1'b1; cs_io.Rout = 1'b1; cs_io.CONin = 1'b1; end
                    ClsJr:   begin cs_io.Gra = 1'b1; cs_io.Rout = 1'b1; cs_io.PCin = 1'b1; end
                    ClsIn:   begin cs_io.InPortOut = 1'b1; cs_io.Gra = 1'b1; cs_io.Rin = 1'b1; end
                    ClsOut:  begin cs_io.Gra = 1'b1; cs_io.Rout = 1'b1; cs_io.OutportIn = 1'b1; end
                    ClsMfhi: begin cs_io.HIout = 1'b1; cs_io.Gra = 1'b1; cs_io.Rin = 1'b1; end
                    ClsMflo: begin cs_io.LOout = 1'b1; cs_io.Gra = 1'b1; cs_io.Rin = 1'b1; end
                    default: ;
                endcase
            end
            StT4: begin
                case (cls)
                    ClsAlu: begin
                        cs_io.Grc = 1'b1; cs_io.Rout = 1'b1; cs_io.Zin = 1'b1; cs_io.OpCode = op;
                    end
                    ClsImm: begin cs_io.Cout = 1'b1; cs_io.Zin = 1'b1; cs_io.OpCode = imm_op; end
                    ClsMul: begin
                        cs_io.Grb = 1'b1; cs_io.Rout = 1'b1; cs_io.Zin = 1'b1; cs_io.OpCode = op;
                    end
                    ClsLd, ClsLdi, ClsSt: begin
                        cs_io.Cout = 1'b1; cs_io.Zin = 1'b1; cs_io.OpCode = ADD_OP;
                    end
                    ClsBr:   begin cs_io.PCout = 1'b1; cs_io.Yin = 1'b1; end
                    default: ;
                endcase
            end
            StT5: begin
                case (cls)
                    ClsAlu, ClsImm, ClsLdi: begin
                        cs_io.Zlowout = 1'b1; cs_io.Gra = 1'b1; cs_io.Rin = 1'b1;
                    end
                    ClsMul:       begin cs_io.Zlowout = 1'b1; cs_io.LOin = 1'b1; end
                    ClsLd, ClsSt: begin cs_io.Zlowout = 1'b1; cs_io.MARin = 1'b1; end
                    ClsBr: begin cs_io.Cout = 1'b1; cs_io.Zin = 1'b1; cs_io.OpCode = ADD_OP; end
                    default: ;
                endcase
            end
            StT6: begin
                case (cls)
                    ClsMul: begin cs_io.Zhighout = 1'b1; cs_io.HIin = 1'b1; end
                    ClsLd:  begin cs_io.Read = 1'b1; cs_io.MDRin = 1'b1; end
                    ClsSt:  begin cs_io.Gra = 1'b1; cs_io.Rout = 1'b1; cs_io.MDRin = 1'b1; end
                    ClsBr:  begin cs_io.Zlowout = con_q; cs_io.PCin = con_q; end
                    default: ;
                endcase
            end
            StT7: begin
                case (cls)
                    ClsLd:   begin cs_io.MDRout = 1'b1; cs_io.Gra = 1'b1; cs_io.Rin = 1'b1; end
                    ClsSt:   cs_io.Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each task drives one scenario and compares the
// packed {run, OpCode, strobes} word against hand-derived expectations every cycle.
module tb_control_sequencer;

    localparam logic [25:0] SPcin  = 26'd1 << 0,  SPcout = 26'd1 << 1,  SIrin  = 26'd1 << 2;
    localparam logic [25:0] SMarin = 26'd1 << 3,  SMdrin = 26'd1 << 4,  SMdrout = 26'd1 << 5;
    localparam logic [25:0] SYin   = 26'd1 << 6,  SZin   = 26'd1 << 7,  SZhi   = 26'd1 << 8;
    localparam logic [25:0] SZlo   = 26'd1 << 9,  SHiin  = 26'd1 << 10, SLoin  = 26'd1 << 12;
    localparam logic [25:0] SRead  = 26'd1 << 14, SCout  = 26'd1 << 16;
    localparam logic [25:0] SGra   = 26'd1 << 17, SGrb   = 26'd1 << 18, SGrc   = 26'd1 << 19;
    localparam logic [25:0] SRin   = 26'd1 << 20, SRout  = 26'd1 << 21, SBaout = 26'd1 << 22;
    localparam logic [25:0] SConin = 26'd1 << 23;

    localparam logic [25:0] F0 = SPcout | SMarin | SYin | SZin;
    localparam logic [25:0] F1 = SZlo | SPcin | SRead | SMdrin;
    localparam logic [25:0] F2 = SMdrout | SIrin;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;

    control_sequencer_if cs1 ();
    control_sequencer_if cs3 ();

    control_sequencer u_dut (
        .clk   (clk),
        .clr   (clr),
        .cs_io (cs1.master)
    );

    control_sequencer #(.MEM_CYCLES(3)) u_dut3 (
        .clk   (clk),
        .clr   (clr),
        .cs_io (cs3.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs1();
        return {cs1.run, cs1.OpCode, cs1.InPortOut, cs1.OutportIn, cs1.CONin, cs1.BAout,
                cs1.Rout, cs1.Rin, cs1.Grc, cs1.Grb, cs1.Gra, cs1.Cout, cs1.Write, cs1.Read,
                cs1.LOout, cs1.LOin, cs1.HIout, cs1.HIin, cs1.Zlowout, cs1.Zhighout, cs1.Zin,
                cs1.Yin, cs1.MDRout, cs1.MDRin, cs1.MARin, cs1.IRin, cs1.PCout, cs1.PCin};
    endfunction

    function automatic logic [31:0] obs3();
        return {cs3.run, cs3.OpCode, cs3.InPortOut, cs3.OutportIn, cs3.CONin, cs3.BAout,
                cs3.Rout, cs3.Rin, cs3.Grc, cs3.Grb, cs3.Gra, cs3.Cout, cs3.Write, cs3.Read,
                cs3.LOout, cs3.LOin, cs3.HIout, cs3.HIin, cs3.Zlowout, cs3.Zhighout, cs3.Zin,
                cs3.Yin, cs3.MDRout, cs3.MDRin, cs3.MARin, cs3.IRin, cs3.PCout, cs3.PCin};
    endfunction

    function automatic logic [31:0] e(input logic [4:0] op, input logic [25:0] m);
        return {1'b1, op, m};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold clr low for two edges, release mid-cycle; the next edge moves RESET to F0.
    task automatic do_reset();
        clr = 1'b0;
        step();
        step();
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        cs1.ir = 32'h1A92_0000;
        cs3.ir = 32'h0080_0055;
        clr = 1'b0;
        step();
        step();
        got = obs1();
        n_checks++;
        if (got !== 32'h0) $display("FAIL reset_outputs: got %h want %h", got, 32'h0);
        else n_pass++;
        n_checks++;
        if (cs1.illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", cs1.illegal);
        else n_pass++;
        got = obs3();
        n_checks++;
        if (got !== 32'h0) $display("FAIL reset_outputs3: got %h want %h", got, 32'h0);
        else n_pass++;
    endtask

    task automatic test_add();
        logic [31:0] exp [7];
        logic [31:0] got;
        cs1.ir = 32'h1A92_0000;
        exp = '{e(5'd27, F0), e(5'd0, F1), e(5'd0, F2), e(5'd0, SGrb | SRout | SYin),
                e(5'd3, SGrc | SRout | SZin), e(5'd0, SZlo | SGra | SRin), e(5'd27, F0)};
        do_reset();
        #1;
        got = obs1();
        n_checks++;
        if (got !== 32'h0) $display("FAIL add_pre_edge: got %h want %h", got, 32'h0);
        else n_pass++;
        for (int i = 0; i < 7; i++) begin
            step();
            got = obs1();
            n_checks++;
            if (got !== exp[i]) $display("FAIL add_c%0d: got %h want %h", i + 1, got, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_ld_mem3();
        logic [31:0] exp [13];
        logic [31:0] got;
        cs3.ir = 32'h0080_0055;
        exp = '{e(5'd27, F0), e(5'd0, F1), e(5'd0, F1), e(5'd0, F1), e(5'd0, F2),
                e(5'd0, SGrb | SBaout | SYin), e(5'd3, SCout | SZin), e(5'd0, SZlo | SMarin),
                e(5'd0, SRead | SMdrin), e(5'd0, SRead | SMdrin), e(5'd0, SRead | SMdrin),
                e(5'd0, SMdrout | SGra | SRin), e(5'd27, F0)};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step();
            got = obs3();
            n_checks++;
            if (got !== exp[i]) $display("FAIL ld3_c%0d: got %h want %h", i + 1, got, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp [8];
        logic [31:0] got;
        cs1.ir = 32'h9180_0010;
        for (int c = 1; c >= 0; c--) begin
            cs1.con_ff = c[0];
            exp = '{e(5'd27, F0), e(5'd0, F1), e(5'd0, F2), e(5'd0, SGra | SRout | SConin),
                    e(5'd0, SPcout | SYin), e(5'd3, SCout | SZin),
                    e(5'd0, c[0] ? (SZlo | SPcin) : 26'd0), e(5'd27, F0)};
            do_reset();
            for (int i = 0; i < 8; i++) begin
                step();
                got = obs1();
                n_checks++;
                if (got !== exp[i])
                    $display("FAIL br_con%0d_c%0d: got %h want %h", c, i + 1, got, exp[i]);
                else n_pass++;
            end
        end
        cs1.con_ff = 1'b0;
    endtask

    task automatic test_halt();
        logic [31:0] exp [3];
        logic [31:0] got;
        cs1.ir = 32'hD000_0000;
        exp = '{e(5'd27, F0), e(5'd0, F1), e(5'd0, F2)};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            got = obs1();
            n_checks++;
            if (got !== exp[i]) $display("FAIL halt_c%0d: got %h want %h", i + 1, got, exp[i]);
            else n_pass++;
        end
        for (int i = 0; i < 20; i++) begin
            step();
            got = obs1();
            n_checks++;
            if (got !== 32'h0) $display("FAIL halted_c%0d: got %h want %h", i, got, 32'h0);
            else n_pass++;
        end
        do_reset();
        step();
        got = obs1();
        n_checks++;
        if (got !== e(5'd27, F0)) $display("FAIL halt_restart: got %h want %h", got, e(5'd27, F0));
        else n_pass++;
    endtask

    task automatic test_reset_mid_ld();
        logic [31:0] got;
        cs1.ir = 32'h0080_0055;
        do_reset();
        for (int i = 0; i < 7; i++) step();
        got = obs1();
        n_checks++;
        if (got !== e(5'd0, SRead | SMdrin))
            $display("FAIL mid_ld_t6: got %h want %h", got, e(5'd0, SRead | SMdrin));
        else n_pass++;
        #1;
        clr = 1'b0;
        #1;
        got = obs1();
        n_checks++;
        if (got !== 32'h0) $display("FAIL mid_ld_abort: got %h want %h", got, 32'h0);
        else n_pass++;
        @(negedge clk);
        clr = 1'b1;
        #1;
        got = obs1();
        n_checks++;
        if (got !== 32'h0) $display("FAIL mid_ld_reset_state: got %h want %h", got, 32'h0);
        else n_pass++;
        step();
        got = obs1();
        n_checks++;
        if (got !== e(5'd27, F0)) $display("FAIL mid_ld_f0: got %h want %h", got, e(5'd27, F0));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [15];
        logic [31:0] got;
        cs1.ir = 32'h7800_0000;
        exp = '{e(5'd27, F0), e(5'd0, F1), e(5'd0, F2), e(5'd0, SGra | SRout | SYin),
                e(5'd15, SGrb | SRout | SZin), e(5'd0, SZlo | SLoin), e(5'd0, SZhi | SHiin),
                e(5'd27, F0), e(5'd0, F1), e(5'd0, F2), e(5'd0, SGra | SRout | SPcin),
                e(5'd27, F0), e(5'd0, F1), e(5'd0, F2), e(5'd27, F0)};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step();
            got = obs1();
            n_checks++;
            if (got !== exp[i]) $display("FAIL b2b_c%0d: got %h want %h", i + 1, got, exp[i]);
            else n_pass++;
            if (i == 7) cs1.ir = 32'h9800_0000;
            if (i == 11) cs1.ir = 32'hC800_0000;
        end
    endtask

    task automatic test_illegal_stop();
        logic [31:0] exp [10];
        logic        exp_ill [10];
        logic [31:0] got;
        cs1.ir = 32'hF800_0000;
        exp = '{e(5'd27, F0), e(5'd0, F1), e(5'd0, F2), e(5'd27, F0), e(5'd0, F1),
                e(5'd0, F2), e(5'd0, SGrb | SRout | SYin), e(5'd3, SGrc | SRout | SZin),
                e(5'd0, SZlo | SGra | SRin), 32'h0};
        exp_ill = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            got = obs1();
            n_checks++;
            if (got !== exp[i]) $display("FAIL ill_c%0d: got %h want %h", i + 1, got, exp[i]);
            else n_pass++;
            n_checks++;
            if (cs1.illegal !== exp_ill[i])
                $display("FAIL ill_flag_c%0d: got %b want %b", i + 1, cs1.illegal, exp_ill[i]);
            else n_pass++;
            if (i == 3) cs1.ir = 32'h1A92_0000;
            if (i == 7) cs1.stop = 1'b1;
        end
        cs1.stop = 1'b0;
    endtask

    initial begin
        clk      = 1'b0;
        clr      = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        cs1.ir = 32'h0; cs1.con_ff = 1'b0; cs1.stop = 1'b0;
        cs3.ir = 32'h0; cs3.con_ff = 1'b0; cs3.stop = 1'b0;
        test_reset();
        test_add();
        test_ld_mem3();
        test_branch();
        test_halt();
        test_reset_mid_ld();
        test_back_to_back();
        test_illegal_stop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
